// File: rtl/fpgart_seg_pkg.sv
// Shared 7-segment constants, FSM state type and decimal limit helper
// for the binary-to-BCD position display.
package fpgart_seg_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    // 10^n, used to derive the largest displayable value per channel.
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// Single-digit decoder: BCD nibble to active-low 7-segment code.
// Dash has priority over blank; nibbles above 9 also show a dash.
module seg7_digit
    import fpgart_seg_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    // Decode with dash/blank overrides.
    always_comb begin
        seg_o = SEG_DASH;
        if (dash_i) begin
            seg_o = SEG_DASH;
        end else if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/pos_bcd_display.sv
// Two-channel binary to 7-segment position display. Both channels are
// converted in lockstep by a shift-add-3 engine, one bit per clock.
// Optional feature macro: LEAD_ZERO_BLANK_EN blanks leading zero digits.
module pos_bcd_display
    import fpgart_seg_pkg::*;
#(
    parameter int unsigned X_WIDTH  = 9,
    parameter int unsigned Y_WIDTH  = 7,
    parameter int unsigned X_DIGITS = 3,
    parameter int unsigned Y_DIGITS = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [X_WIDTH-1:0]    x_pos,
    input  logic [Y_WIDTH-1:0]    y_pos,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  x_ovf,
    output logic                  y_ovf,
    output logic [4*X_DIGITS-1:0] x_bcd,
    output logic [4*Y_DIGITS-1:0] y_bcd,
    output logic [7*X_DIGITS-1:0] x_hex,
    output logic [7*Y_DIGITS-1:0] y_hex
);

    localparam int unsigned N    = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    localparam int unsigned CW   = $clog2(N + 1);
    // One spare nibble so overflowing values still convert cleanly.
    localparam int unsigned XS   = 4 * X_DIGITS + 4;
    localparam int unsigned YS   = 4 * Y_DIGITS + 4;
    localparam int unsigned XLim = pow10(X_DIGITS) - 1;
    localparam int unsigned YLim = pow10(Y_DIGITS) - 1;

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [N-1:0]          x_bin_q, y_bin_q;
    logic [XS-1:0]         x_scr_q;
    logic [YS-1:0]         y_scr_q;
    logic                  x_ovf_s_q, y_ovf_s_q;
    logic                  busy_q, done_q, x_ovf_q, y_ovf_q;
    logic [4*X_DIGITS-1:0] x_bcd_q;
    logic [4*Y_DIGITS-1:0] y_bcd_q;
    logic [7*X_DIGITS-1:0] x_hex_q;
    logic [7*Y_DIGITS-1:0] y_hex_q;

    logic [XS-1:0]         x_adj, x_scr_d;
    logic [YS-1:0]         y_adj, y_scr_d;
    logic [N-1:0]          x_bin_d, y_bin_d;
    logic [X_DIGITS-1:0]   x_blank;
    logic [Y_DIGITS-1:0]   y_blank;
    logic [7*X_DIGITS-1:0] x_hex_d;
    logic [7*Y_DIGITS-1:0] y_hex_d;

    // One double-dabble step per channel: add 3 to nibbles >= 5, then shift.
    always_comb begin
        x_adj = x_scr_q;
        for (int i = 0; i < int'(X_DIGITS) + 1; i++) begin
            if (x_adj[4*i+:4] >= 4'd5) x_adj[4*i+:4] = x_adj[4*i+:4] + 4'd3;
        end
        y_adj = y_scr_q;
        for (int i = 0; i < int'(Y_DIGITS) + 1; i++) begin
            if (y_adj[4*i+:4] >= 4'd5) y_adj[4*i+:4] = y_adj[4*i+:4] + 4'd3;
        end
        x_scr_d = {x_adj[XS-2:0], x_bin_q[N-1]};
        y_scr_d = {y_adj[YS-2:0], y_bin_q[N-1]};
        x_bin_d = {x_bin_q[N-2:0], 1'b0};
        y_bin_d = {y_bin_q[N-2:0], 1'b0};
    end

`ifdef LEAD_ZERO_BLANK_EN
    // A digit is blanked when it and every higher digit are zero; ones never blanks.
    always_comb begin
        logic run;
        x_blank = '0;
        run = 1'b1;
        for (int i = int'(X_DIGITS) - 1; i >= 1; i--) begin
            run = run & (x_scr_d[4*i+:4] == 4'd0);
            x_blank[i] = run;
        end
        y_blank = '0;
        run = 1'b1;
        for (int i = int'(Y_DIGITS) - 1; i >= 1; i--) begin
            run = run & (y_scr_d[4*i+:4] == 4'd0);
            y_blank[i] = run;
        end
    end
`else
    assign x_blank = '0;
    assign y_blank = '0;
`endif

    for (genvar i = 0; i < X_DIGITS; i++) begin : g_xseg
        seg7_digit u_seg (
            .digit_i (x_scr_d[4*i+:4]),
            .blank_i (x_blank[i]),
            .dash_i  (x_ovf_s_q),
            .seg_o   (x_hex_d[7*i+:7])
        );
    end

    for (genvar i = 0; i < Y_DIGITS; i++) begin : g_yseg
        seg7_digit u_seg (
            .digit_i (y_scr_d[4*i+:4]),
            .blank_i (y_blank[i]),
            .dash_i  (y_ovf_s_q),
            .seg_o   (y_hex_d[7*i+:7])
        );
    end

    // Control FSM, shift engine and commit registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            x_bin_q   <= '0;
            y_bin_q   <= '0;
            x_scr_q   <= '0;
            y_scr_q   <= '0;
            x_ovf_s_q <= 1'b0;
            y_ovf_s_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            x_ovf_q   <= 1'b0;
            y_ovf_q   <= 1'b0;
            x_bcd_q   <= '0;
            y_bcd_q   <= '0;
            x_hex_q   <= {X_DIGITS{SEG_DASH}};
            y_hex_q   <= {Y_DIGITS{SEG_DASH}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_bin_q   <= N'(x_pos);
                        y_bin_q   <= N'(y_pos);
                        x_scr_q   <= '0;
                        y_scr_q   <= '0;
                        x_ovf_s_q <= (32'(x_pos) > XLim);
                        y_ovf_s_q <= (32'(y_pos) > YLim);
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    x_scr_q <= x_scr_d;
                    y_scr_q <= y_scr_d;
                    x_bin_q <= x_bin_d;
                    y_bin_q <= y_bin_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        x_bcd_q <= x_scr_d[4*X_DIGITS-1:0];
                        y_bcd_q <= y_scr_d[4*Y_DIGITS-1:0];
                        x_hex_q <= x_hex_d;
                        y_hex_q <= y_hex_d;
                        x_ovf_q <= x_ovf_s_q;
                        y_ovf_q <= y_ovf_s_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign x_ovf = x_ovf_q;
    assign y_ovf = y_ovf_q;
    assign x_bcd = x_bcd_q;
    assign y_bcd = y_bcd_q;
    assign x_hex = x_hex_q;
    assign y_hex = y_hex_q;

endmodule

// File: tb/tb_pos_bcd_display.sv
// Scoreboard bench for pos_bcd_display with default parameters.
module tb_pos_bcd_display;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S9 = 7'h10;
    localparam logic [6:0] SD = 7'h3F, SB = 7'h7F;

    typedef struct {
        logic [11:0] xb;
        logic [7:0]  yb;
        logic [20:0] xh;
        logic [13:0] yh;
        logic        xo;
        logic        yo;
        int          acc;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [8:0]  x_pos = '0;
    logic [6:0]  y_pos = '0;
    logic        start = 1'b0;
    logic        busy, done, x_ovf, y_ovf;
    logic [11:0] x_bcd;
    logic [7:0]  y_bcd;
    logic [20:0] x_hex;
    logic [13:0] y_hex;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_done = 0;
    exp_t q[$];
    exp_t e;

    pos_bcd_display dut (
        .clock  (clock),
        .resetn (resetn),
        .x_pos  (x_pos),
        .y_pos  (y_pos),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .x_ovf  (x_ovf),
        .y_ovf  (y_ovf),
        .x_bcd  (x_bcd),
        .y_bcd  (y_bcd),
        .x_hex  (x_hex),
        .y_hex  (y_hex)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clock) begin
        exp_t m;
        if (resetn && done === 1'b1) begin
            n_done++;
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                m = q.pop_front();
                chk("latency", 32'(cyc - m.acc), 32'd9);
                chk("x_bcd", 32'(x_bcd), 32'(m.xb));
                chk("y_bcd", 32'(y_bcd), 32'(m.yb));
                chk("x_hex", 32'(x_hex), 32'(m.xh));
                chk("y_hex", 32'(y_hex), 32'(m.yh));
                chk("x_ovf", 32'(x_ovf), 32'(m.xo));
                chk("y_ovf", 32'(y_ovf), 32'(m.yo));
                chk("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    // Called at a negedge: start is sampled on the next posedge.
    task automatic issue(input logic [8:0] x, input logic [6:0] y, input exp_t ex);
        exp_t t;
        t = ex;
        x_pos = x;
        y_pos = y;
        start = 1'b1;
        t.acc = cyc + 1;
        q.push_back(t);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done === 1'b1) seen = 1;
            else @(negedge clock);
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_ovf"}, 32'({x_ovf, y_ovf}), 32'd0);
        chk({name, "_x_hex"}, 32'(x_hex), 32'({SD, SD, SD}));
        chk({name, "_y_hex"}, 32'(y_hex), 32'({SD, SD}));
        chk({name, "_bcd"}, {12'd0, x_bcd, y_bcd}, 32'd0);
    endtask

    initial begin
        // Reset held for two cycles.
        repeat (2) @(negedge clock);
        chk_reset_state("reset");
        resetn = 1'b1;
        @(negedge clock);

        // 319 / 45
        e = '{xb: 12'h319, yb: 8'h45, xh: {S3, S1, S9}, yh: {S4, S5}, xo: 0, yo: 0, acc: 0};
        issue(9'd319, 7'd45, e);
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_done("t2");
        @(negedge clock);

        // 7 / 0: leading zeros
`ifdef LEAD_ZERO_BLANK_EN
        e = '{xb: 12'h007, yb: 8'h00, xh: {SB, SB, S7}, yh: {SB, S0}, xo: 0, yo: 0, acc: 0};
`else
        e = '{xb: 12'h007, yb: 8'h00, xh: {S0, S0, S7}, yh: {S0, S0}, xo: 0, yo: 0, acc: 0};
`endif
        issue(9'd7, 7'd0, e);
        wait_done("t3");
        @(negedge clock);

        // Y overflow: 120 > 99
`ifdef LEAD_ZERO_BLANK_EN
        e = '{xb: 12'h042, yb: 8'h20, xh: {SB, S4, S2}, yh: {SD, SD}, xo: 0, yo: 1, acc: 0};
`else
        e = '{xb: 12'h042, yb: 8'h20, xh: {S0, S4, S2}, yh: {SD, SD}, xo: 0, yo: 1, acc: 0};
`endif
        issue(9'd42, 7'd120, e);
        wait_done("t4");
        @(negedge clock);

        // Ignored starts while busy, then back-to-back start in the done cycle.
        e = '{xb: 12'h100, yb: 8'h99, xh: {S1, S0, S0}, yh: {S9, S9}, xo: 0, yo: 0, acc: 0};
        issue(9'd100, 7'd99, e);
        repeat (2) @(negedge clock);
        x_pos = 9'd5;
        y_pos = 7'd5;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("hold_x_bcd_busy", 32'(x_bcd), 32'h042);
        chk("hold_y_hex_busy", 32'(y_hex), 32'({SD, SD}));
        repeat (2) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("busy_mid", 32'(busy), 32'd1);
        wait_done("t5a");
`ifdef LEAD_ZERO_BLANK_EN
        e = '{xb: 12'h256, yb: 8'h01, xh: {S2, S5, S6}, yh: {SB, S1}, xo: 0, yo: 0, acc: 0};
`else
        e = '{xb: 12'h256, yb: 8'h01, xh: {S2, S5, S6}, yh: {S0, S1}, xo: 0, yo: 0, acc: 0};
`endif
        issue(9'd256, 7'd1, e);
        wait_done("t5b");
        @(negedge clock);

        // Reset in SHIFT cycle 4 aborts with no done.
        x_pos = 9'd300;
        y_pos = 7'd50;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        chk_reset_state("abort");
        resetn = 1'b1;
        repeat (14) @(negedge clock);
        chk("abort_still_reset_bcd", 32'(x_bcd), 32'd0);

        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("done_count", 32'(n_done), 32'd5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
